// File: rtl/rob_tag_allocator.sv
// rtl/rob_tag_allocator.sv - in-order ROB tag allocator and write-side driver of the bypass register file
// Optional same-cycle complete-to-commit path is enabled by defining ROB_COMPLETE_BYPASS_EN.
module rob_tag_allocator #(
    parameter int NUM_ENTRIES       = 8,
    parameter int LOG_NUM_ENTRIES   = 3,
    parameter int NUM_REGISTERS     = 8,
    parameter int LOG_NUM_REGISTERS = 3
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         alloc_valid_i,
    input  logic                         alloc_writes_i,
    input  logic [LOG_NUM_REGISTERS-1:0] alloc_dest_i,
    output logic                         alloc_ready_o,
    output logic [LOG_NUM_ENTRIES-1:0]   alloc_tag_o,
    output logic                         bypass_we_o,
    output logic [LOG_NUM_REGISTERS-1:0] bypass_waddr_o,
    output logic [LOG_NUM_ENTRIES-1:0]   bypass_d_o,
    input  logic                         complete_valid_i,
    input  logic [LOG_NUM_ENTRIES-1:0]   complete_tag_i,
    output logic                         commit_valid_o,
    output logic [LOG_NUM_ENTRIES-1:0]   commit_tag_o,
    output logic [LOG_NUM_REGISTERS-1:0] commit_dest_o,
    output logic                         commit_writes_o,
    input  logic                         commit_ready_i,
    input  logic                         flush_i,
    output logic [LOG_NUM_ENTRIES:0]     count_o,
    output logic                         empty_o,
    output logic                         full_o
);

    localparam logic [LOG_NUM_ENTRIES:0] FULL_COUNT = (LOG_NUM_ENTRIES+1)'(NUM_ENTRIES);

    logic [NUM_ENTRIES-1:0]                         valid_q, valid_d;
    logic [NUM_ENTRIES-1:0]                         done_q, done_d;
    logic [NUM_ENTRIES-1:0]                         writes_q, writes_d;
    logic [NUM_ENTRIES-1:0][LOG_NUM_REGISTERS-1:0]  dest_q, dest_d;
    logic [LOG_NUM_ENTRIES-1:0]                     head_q, head_d;
    logic [LOG_NUM_ENTRIES-1:0]                     tail_q, tail_d;
    logic [LOG_NUM_ENTRIES:0]                       count_q, count_d;

    logic full;
    logic alloc_fire;
    logic commit_valid;
    logic commit_fire;

    assign full       = (count_q == FULL_COUNT);
    assign alloc_fire = alloc_valid_i & ~full & ~flush_i;

`ifdef ROB_COMPLETE_BYPASS_EN
    // A completion aimed at the live head retires it in the same cycle.
    assign commit_valid = valid_q[head_q] &
                          (done_q[head_q] | (complete_valid_i & (complete_tag_i == head_q)));
`else
    assign commit_valid = valid_q[head_q] & done_q[head_q];
`endif

    assign commit_fire = commit_valid & commit_ready_i & ~flush_i;

    assign alloc_ready_o   = ~full;
    assign alloc_tag_o     = tail_q;
    assign bypass_we_o     = alloc_fire & alloc_writes_i;
    assign bypass_waddr_o  = alloc_dest_i;
    assign bypass_d_o      = tail_q;
    assign commit_valid_o  = commit_valid;
    assign commit_tag_o    = head_q;
    assign commit_dest_o   = dest_q[head_q];
    assign commit_writes_o = writes_q[head_q];
    assign count_o         = count_q;
    assign empty_o         = (count_q == '0);
    assign full_o          = full;

    always_comb begin
        valid_d  = valid_q;
        done_d   = done_q;
        writes_d = writes_q;
        dest_d   = dest_q;
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        if (flush_i) begin
            valid_d = '0;
            done_d  = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            // Uses the registered valid, so a tag being allocated right now cannot be completed.
            if (complete_valid_i && valid_q[complete_tag_i]) begin
                done_d[complete_tag_i] = 1'b1;
            end
            if (alloc_fire) begin
                valid_d[tail_q]  = 1'b1;
                done_d[tail_q]   = 1'b0;
                dest_d[tail_q]   = alloc_dest_i;
                writes_d[tail_q] = alloc_writes_i;
                tail_d           = tail_q + 1'b1;
            end
            if (commit_fire) begin
                valid_d[head_q] = 1'b0;
                done_d[head_q]  = 1'b0;
                head_d          = head_q + 1'b1;
            end
            case ({alloc_fire, commit_fire})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q  <= '0;
            done_q   <= '0;
            writes_q <= '0;
            dest_q   <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
        end else begin
            valid_q  <= valid_d;
            done_q   <= done_d;
            writes_q <= writes_d;
            dest_q   <= dest_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
        end
    end

    a_count_bounded: assert property (@(posedge clk_i) disable iff (!rst_ni)
        count_q <= FULL_COUNT);

    a_ptr_distance: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (tail_q - head_q) == count_q[LOG_NUM_ENTRIES-1:0]);

    a_dest_in_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
        alloc_valid_i |-> (32'(alloc_dest_i) < NUM_REGISTERS));

endmodule

// File: tb/tb_rob_tag_allocator.sv
// tb/tb_rob_tag_allocator.sv - scoreboard bench for rob_tag_allocator
module tb_rob_tag_allocator;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       alloc_valid = 1'b0, alloc_writes = 1'b0;
    logic [2:0] alloc_dest = '0;
    logic       alloc_ready;
    logic [2:0] alloc_tag;
    logic       bypass_we;
    logic [2:0] bypass_waddr, bypass_d;
    logic       complete_valid = 1'b0;
    logic [2:0] complete_tag = '0;
    logic       commit_valid;
    logic [2:0] commit_tag, commit_dest;
    logic       commit_writes;
    logic       commit_ready = 1'b0;
    logic       flush = 1'b0;
    logic [3:0] count;
    logic       empty, full;

    int n_checks = 0;
    int n_errors = 0;

    logic [5:0] exp_byp[$];
    logic [6:0] exp_cmt[$];

    always #5 clk = ~clk;

    rob_tag_allocator dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .alloc_valid_i    (alloc_valid),
        .alloc_writes_i   (alloc_writes),
        .alloc_dest_i     (alloc_dest),
        .alloc_ready_o    (alloc_ready),
        .alloc_tag_o      (alloc_tag),
        .bypass_we_o      (bypass_we),
        .bypass_waddr_o   (bypass_waddr),
        .bypass_d_o       (bypass_d),
        .complete_valid_i (complete_valid),
        .complete_tag_i   (complete_tag),
        .commit_valid_o   (commit_valid),
        .commit_tag_o     (commit_tag),
        .commit_dest_o    (commit_dest),
        .commit_writes_o  (commit_writes),
        .commit_ready_i   (commit_ready),
        .flush_i          (flush),
        .count_o          (count),
        .empty_o          (empty),
        .full_o           (full)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: every bypass write and every commit handshake must match the next queued expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bypass_we) begin
                n_checks++;
                if (exp_byp.size() == 0) begin
                    n_errors++;
                    $display("FAIL bypass_unexpected: got waddr=%0d d=%0d expected none",
                             bypass_waddr, bypass_d);
                end else begin
                    logic [5:0] e;
                    e = exp_byp.pop_front();
                    if ({bypass_waddr, bypass_d} != e) begin
                        n_errors++;
                        $display("FAIL bypass_write: got waddr=%0d d=%0d expected waddr=%0d d=%0d",
                                 bypass_waddr, bypass_d, e[5:3], e[2:0]);
                    end
                end
            end
            if (commit_valid && commit_ready && !flush) begin
                n_checks++;
                if (exp_cmt.size() == 0) begin
                    n_errors++;
                    $display("FAIL commit_unexpected: got tag=%0d dest=%0d writes=%0d expected none",
                             commit_tag, commit_dest, commit_writes);
                end else begin
                    logic [6:0] e;
                    e = exp_cmt.pop_front();
                    if ({commit_tag, commit_dest, commit_writes} != e) begin
                        n_errors++;
                        $display("FAIL commit: got tag=%0d dest=%0d writes=%0d expected tag=%0d dest=%0d writes=%0d",
                                 commit_tag, commit_dest, commit_writes, e[6:4], e[3:1], e[0]);
                    end
                end
            end
        end
    end

    // Drive one cycle of inputs just after posedge; return just after the following negedge.
    task automatic cyc(input logic av, input logic aw, input logic [2:0] ad,
                       input logic cv, input logic [2:0] ct, input logic cr, input logic fl);
        @(posedge clk);
        #1;
        alloc_valid    = av;
        alloc_writes   = aw;
        alloc_dest     = ad;
        complete_valid = cv;
        complete_tag   = ct;
        commit_ready   = cr;
        flush          = fl;
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [2:0] t;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_alloc_ready", alloc_ready, 1);
        chk("rst_alloc_tag", alloc_tag, 0);
        chk("rst_bypass_we", bypass_we, 0);
        chk("rst_commit_valid", commit_valid, 0);
        chk("rst_commit_tag", commit_tag, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_count", count, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // single allocate with register write
        exp_byp.push_back({3'd5, 3'd0});
        cyc(1'b1, 1'b1, 3'd5, 1'b0, 3'd0, 1'b0, 1'b0);
        chk("t1_bypass_we", bypass_we, 1);
        chk("t1_waddr", bypass_waddr, 5);
        chk("t1_d", bypass_d, 0);
        idle();
        chk("t1_count", count, 1);
        chk("t1_tail", alloc_tag, 1);
        chk("t1_empty", empty, 0);

        // fill remaining 7 entries; tag 3 does not write a register
        for (int i = 1; i < 8; i++) begin
            t = 3'(i);
            if (i != 3) exp_byp.push_back({t, t});
            cyc(1'b1, (i != 3), t, 1'b0, 3'd0, 1'b0, 1'b0);
        end
        cyc(1'b1, 1'b1, 3'd6, 1'b0, 3'd0, 1'b0, 1'b0);
        chk("full_flag", full, 1);
        chk("full_alloc_ready", alloc_ready, 0);
        chk("full_no_bypass", bypass_we, 0);
        idle();
        chk("full_count", count, 8);
        chk("full_tail_wrapped", alloc_tag, 0);

        // commit while full: no alloc that cycle, reused tag the next
        cyc(1'b0, 1'b0, 3'd0, 1'b1, 3'd0, 1'b0, 1'b0);
        exp_cmt.push_back({3'd0, 3'd5, 1'b1});
        cyc(1'b1, 1'b1, 3'd2, 1'b0, 3'd0, 1'b1, 1'b0);
        chk("fullcommit_valid", commit_valid, 1);
        chk("fullcommit_tag", commit_tag, 0);
        chk("fullcommit_no_alloc", bypass_we, 0);
        exp_byp.push_back({3'd2, 3'd0});
        cyc(1'b1, 1'b1, 3'd2, 1'b0, 3'd0, 1'b1, 1'b0);
        chk("reuse_ready", alloc_ready, 1);
        chk("reuse_tag", alloc_tag, 0);
        chk("reuse_count", count, 7);
        chk("reuse_head_blocked", commit_valid, 0);
        idle();
        chk("refill_count", count, 8);
        chk("refill_tail", alloc_tag, 1);

        // flush wins over alloc, complete and commit
        cyc(1'b1, 1'b1, 3'd4, 1'b1, 3'd1, 1'b1, 1'b1);
        chk("flush_no_bypass", bypass_we, 0);
        idle();
        chk("flush_count", count, 0);
        chk("flush_empty", empty, 1);
        chk("flush_full", full, 0);
        chk("flush_tail", alloc_tag, 0);
        chk("flush_head", commit_tag, 0);
        chk("flush_commit_valid", commit_valid, 0);

        // out-of-order completion, in-order retirement
        exp_byp.push_back({3'd1, 3'd0});
        cyc(1'b1, 1'b1, 3'd1, 1'b0, 3'd0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 3'd2, 1'b0, 3'd0, 1'b0, 1'b0);
        exp_byp.push_back({3'd3, 3'd2});
        cyc(1'b1, 1'b1, 3'd3, 1'b0, 3'd0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 3'd0, 1'b1, 3'd2, 1'b0, 1'b0);
        chk("ooo_tag2_no_commit", commit_valid, 0);
        cyc(1'b0, 1'b0, 3'd0, 1'b1, 3'd0, 1'b0, 1'b0);
        exp_cmt.push_back({3'd0, 3'd1, 1'b1});
        cyc(1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 1'b0);
        chk("ooo_head0_valid", commit_valid, 1);
        cyc(1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 1'b0);
        chk("ooo_tag1_blocks", commit_valid, 0);
        chk("ooo_head1", commit_tag, 1);
        chk("ooo_count", count, 2);
        cyc(1'b0, 1'b0, 3'd0, 1'b1, 3'd1, 1'b0, 1'b0);
        exp_cmt.push_back({3'd1, 3'd2, 1'b0});
        exp_cmt.push_back({3'd2, 3'd3, 1'b1});
        cyc(1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 1'b0);
        chk("ooo_commit_tag1", commit_tag, 1);
        cyc(1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 1'b0);
        chk("ooo_commit_tag2", commit_tag, 2);
        idle();
        chk("ooo_drained", empty, 1);

        // complete the head with commit_ready high
        exp_byp.push_back({3'd7, 3'd3});
        cyc(1'b1, 1'b1, 3'd7, 1'b0, 3'd0, 1'b0, 1'b0);
`ifdef ROB_COMPLETE_BYPASS_EN
        exp_cmt.push_back({3'd3, 3'd7, 1'b1});
        cyc(1'b0, 1'b0, 3'd0, 1'b1, 3'd3, 1'b1, 1'b0);
        chk("headcomplete_same_cycle", commit_valid, 1);
`else
        cyc(1'b0, 1'b0, 3'd0, 1'b1, 3'd3, 1'b1, 1'b0);
        chk("headcomplete_same_cycle", commit_valid, 0);
        exp_cmt.push_back({3'd3, 3'd7, 1'b1});
        cyc(1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 1'b0);
        chk("headcomplete_next_cycle", commit_valid, 1);
`endif
        idle();
        chk("headcomplete_count", count, 0);

        // completing a tag in its own allocate cycle is ignored
        cyc(1'b1, 1'b0, 3'd6, 1'b1, 3'd4, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 1'b0);
        chk("same_cycle_complete_ignored", commit_valid, 0);
        chk("same_cycle_count", count, 1);
        cyc(1'b0, 1'b0, 3'd0, 1'b1, 3'd4, 1'b0, 1'b0);
        exp_cmt.push_back({3'd4, 3'd6, 1'b0});
        cyc(1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 1'b0);
        chk("late_complete_valid", commit_valid, 1);
        idle();
        idle();
        chk("final_empty", empty, 1);
        chk("bypass_queue_drained", exp_byp.size(), 0);
        chk("commit_queue_drained", exp_cmt.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
